// File: rtl/fft_ctrl_pkg.sv
// Shared constants and controller state encoding for the FFT frame scheduler.
package fft_ctrl_pkg;

  localparam int N_POINTS = 64;
  localparam int LOG2_N   = 6;
  localparam int DATA_W   = 16;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    RUN,
    DRAIN
  } ctrl_state_t;

endpackage

// File: rtl/fft_frame_scheduler_buffer.sv
// Fill-side frame buffer: accepts streaming samples until a full frame is held,
// then stays frozen until the controller clears it while launching the core.
module fft_frame_buffer
  import fft_ctrl_pkg::*;
(
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  input  logic [DATA_W-1:0]                in_re,
  input  logic [DATA_W-1:0]                in_im,
  input  logic                             clear,
  output logic                             in_ready,
  output logic                             buf_full,
  output logic [N_POINTS-1:0][DATA_W-1:0]  buf_re,
  output logic [N_POINTS-1:0][DATA_W-1:0]  buf_im
);

  localparam logic [LOG2_N-1:0] LAST_IDX = LOG2_N'(N_POINTS - 1);

  logic [LOG2_N-1:0] wr_ptr;

  assign in_ready = ~buf_full;

  // Falling-edge state so the buffer moves in step with the FFT core.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      buf_full <= 1'b0;
      buf_re   <= '0;
      buf_im   <= '0;
    end else if (clear) begin
      buf_full <= 1'b0;
    end else if (in_valid && !buf_full) begin
      buf_re[wr_ptr] <= in_re;
      buf_im[wr_ptr] <= in_im;
      wr_ptr         <= wr_ptr + 1'b1;
      if (wr_ptr == LAST_IDX) begin
        buf_full <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/fft_frame_scheduler.sv
// Sequencing controller for the 64-point FFT core: fills a frame, launches the
// core, watches for a hung core, and streams results out in bin order.
module fft_frame_scheduler
  import fft_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [DATA_W-1:0]                in_re,
  input  logic [DATA_W-1:0]                in_im,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DATA_W-1:0]                out_re,
  output logic [DATA_W-1:0]                out_im,
  output logic [LOG2_N-1:0]                out_index,
  output logic                             out_last,
  output logic                             fft_start,
  output logic [N_POINTS-1:0][DATA_W-1:0]  fft_in_re,
  output logic [N_POINTS-1:0][DATA_W-1:0]  fft_in_im,
  input  logic                             fft_done,
  input  logic [N_POINTS-1:0][DATA_W-1:0]  fft_out_re,
  input  logic [N_POINTS-1:0][DATA_W-1:0]  fft_out_im,
  output logic                             busy,
  output logic                             timeout_err,
  output logic [15:0]                      frame_count
);

  localparam int                TIMER_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [LOG2_N-1:0] LAST_IDX = LOG2_N'(N_POINTS - 1);

  ctrl_state_t        state;
  logic [TIMER_W-1:0] timer;
  logic [TIMER_W-1:0] timer_next;
  logic [LOG2_N-1:0]  rd_ptr;
  logic               buf_full;
  logic               buf_clear;

  assign buf_clear = (state == LAUNCH);

  fft_frame_buffer u_buffer (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_re    (in_re),
    .in_im    (in_im),
    .clear    (buf_clear),
    .in_ready (in_ready),
    .buf_full (buf_full),
    .buf_re   (fft_in_re),
    .buf_im   (fft_in_im)
  );

  // Saturating so a stuck core can never wrap the watchdog back to zero.
  assign timer_next = (timer == '1) ? timer : timer + 1'b1;

  assign out_re    = fft_out_re[rd_ptr];
  assign out_im    = fft_out_im[rd_ptr];
  assign out_index = rd_ptr;
  assign out_last  = out_valid && (rd_ptr == LAST_IDX);

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      timer       <= '0;
      rd_ptr      <= '0;
      fft_start   <= 1'b0;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      frame_count <= '0;
    end else begin
      fft_start <= 1'b0;
      case (state)
        IDLE: begin
          if (buf_full) begin
            state     <= LAUNCH;
            fft_start <= 1'b1;
            busy      <= 1'b1;
          end
        end
        LAUNCH: begin
          state <= RUN;
          timer <= '0;
        end
        RUN: begin
          // A done pulse on the expiry edge still counts as a good finish.
          if (fft_done) begin
            state     <= DRAIN;
            rd_ptr    <= '0;
            out_valid <= 1'b1;
          end else if (timer_next >= TIMER_W'(TIMEOUT_CYCLES)) begin
            state       <= IDLE;
            busy        <= 1'b0;
            timeout_err <= 1'b1;
            timer       <= timer_next;
          end else begin
            timer <= timer_next;
          end
        end
        DRAIN: begin
          if (out_ready) begin
            rd_ptr <= rd_ptr + 1'b1;
            if (rd_ptr == LAST_IDX) begin
              frame_count <= frame_count + 1'b1;
              out_valid   <= 1'b0;
              // Core results are only overwritten after we finish reading them.
              if (buf_full) begin
                state     <= LAUNCH;
                fft_start <= 1'b1;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fft_frame_scheduler.sv
// Directed bench for fft_frame_scheduler with a behavioural FFT core model and
// an output scoreboard fed from the source stimulus.
module tb_fft_frame_scheduler;
  import fft_ctrl_pkg::*;

  localparam int PERIOD     = 10;
  localparam int DONE_DELAY = 200;
  localparam int TIMEOUT    = 1023;

  typedef struct packed {
    logic [DATA_W-1:0] re;
    logic [DATA_W-1:0] im;
    logic [LOG2_N-1:0] idx;
  } exp_t;

  logic                            clk = 1'b0;
  logic                            rst;
  logic                            in_valid;
  logic                            in_ready;
  logic [DATA_W-1:0]               in_re;
  logic [DATA_W-1:0]               in_im;
  logic                            out_valid;
  logic                            out_ready = 1'b1;
  logic [DATA_W-1:0]               out_re;
  logic [DATA_W-1:0]               out_im;
  logic [LOG2_N-1:0]               out_index;
  logic                            out_last;
  logic                            fft_start;
  logic [N_POINTS-1:0][DATA_W-1:0] fft_in_re;
  logic [N_POINTS-1:0][DATA_W-1:0] fft_in_im;
  logic                            fft_done = 1'b0;
  logic [N_POINTS-1:0][DATA_W-1:0] fft_out_re;
  logic [N_POINTS-1:0][DATA_W-1:0] fft_out_im;
  logic                            busy;
  logic                            timeout_err;
  logic [15:0]                     frame_count;

  int   checks = 0;
  int   passes = 0;
  exp_t exp_q[$];

  int   mode = 0;
  logic core_en = 1'b1;
  int   stray_req = 0;
  int   stray_ack = 0;
  logic b2b_armed = 1'b0;
  logic b2b_done = 1'b0;
  logic valid_seen = 1'b0;
  logic prev_valid = 1'b0;
  logic prev_start = 1'b0;
  logic held_valid = 1'b0;
  logic [DATA_W-1:0] held_re;
  logic [LOG2_N-1:0] held_idx;
  int   dcyc = 0;
  int   last_drain_len = 0;
  time  last_hs_time = 0;
  time  last_start_time = 0;

  logic [N_POINTS-1:0][DATA_W-1:0] lat_re;
  logic [N_POINTS-1:0][DATA_W-1:0] lat_im;
  logic core_busy = 1'b0;
  int   core_cnt = 0;

  fft_frame_scheduler #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_re       (in_re),
    .in_im       (in_im),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_re      (out_re),
    .out_im      (out_im),
    .out_index   (out_index),
    .out_last    (out_last),
    .fft_start   (fft_start),
    .fft_in_re   (fft_in_re),
    .fft_in_im   (fft_in_im),
    .fft_done    (fft_done),
    .fft_out_re  (fft_out_re),
    .fft_out_im  (fft_out_im),
    .busy        (busy),
    .timeout_err (timeout_err),
    .frame_count (frame_count)
  );

  always #(PERIOD / 2) clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Core model: latches on start, answers with re+1000 / im after DONE_DELAY.
  always @(posedge clk) begin
    fft_done = 1'b0;
    if (stray_req != stray_ack) begin
      fft_done  = 1'b1;
      stray_ack = stray_req;
    end else if (fft_start) begin
      lat_re    = fft_in_re;
      lat_im    = fft_in_im;
      core_cnt  = 0;
      core_busy = core_en;
    end else if (core_busy) begin
      core_cnt++;
      if (core_cnt == DONE_DELAY) begin
        for (int k = 0; k < N_POINTS; k++) begin
          fft_out_re[k] = lat_re[k] + 16'd1000;
          fft_out_im[k] = lat_im[k];
        end
        fft_done  = 1'b1;
        core_busy = 1'b0;
      end
    end
  end

  // Start pulse monitor.
  always @(posedge clk) begin
    if (fft_start) begin
      check("start_one_cycle", 32'(prev_start), 32'd0);
      last_start_time = $time;
      if (b2b_armed && !b2b_done) begin
        check("b2b_start_gap", 32'(($time - last_hs_time) / PERIOD), 32'd1);
        b2b_done = 1'b1;
      end
    end
    prev_start = fft_start;
  end

  // Sink: drives out_ready for the upcoming falling edge and scores each word.
  always @(posedge clk) begin
    if (out_valid) begin
      valid_seen = 1'b1;
      if (!prev_valid) dcyc = 0;
      case (mode)
        1:       out_ready = dcyc[0];
        2:       out_ready = (out_index != 6'd30);
        default: out_ready = 1'b1;
      endcase
      if (held_valid) begin
        check("hold_re", 32'(out_re), 32'(held_re));
        check("hold_index", 32'(out_index), 32'(held_idx));
        held_valid = 1'b0;
      end
      if (out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", 32'(out_valid), 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("out_re", 32'(out_re), 32'(e.re));
          check("out_im", 32'(out_im), 32'(e.im));
          check("out_index", 32'(out_index), 32'(e.idx));
          check("out_last", 32'(out_last), 32'(e.idx == 6'd63));
          if (e.idx == 6'd63) last_hs_time = $time;
        end
      end else begin
        held_valid = 1'b1;
        held_re    = out_re;
        held_idx   = out_index;
      end
      dcyc++;
    end else begin
      if (prev_valid) last_drain_len = dcyc;
      held_valid = 1'b0;
      out_ready  = 1'b1;
    end
    prev_valid = out_valid;
  end

  task automatic send_sample(input logic [DATA_W-1:0] re, input logic [DATA_W-1:0] im,
                             input logic [LOG2_N-1:0] idx);
    int waited;
    waited   = 0;
    in_valid = 1'b1;
    in_re    = re;
    in_im    = im;
    while (!in_ready && waited < 2000) begin
      @(posedge clk);
      waited++;
    end
    if (!in_ready) check("source_wait", 32'(in_ready), 32'd1);
    exp_q.push_back('{re: re + 16'd1000, im: im, idx: idx});
    @(posedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input int base, input int im_step);
    for (int k = 0; k < N_POINTS; k++) begin
      send_sample(16'(base + k), 16'(im_step * k), 6'(k));
    end
  endtask

  task automatic wait_frames(input int n, input int limit);
    int w;
    w = 0;
    while (frame_count != 16'(n) && w < limit) begin
      @(posedge clk);
      w++;
    end
    check("frame_count", 32'(frame_count), 32'(n));
    @(posedge clk);
  endtask

  initial begin
    #(400000);
    $display("[TB] FAIL global_timeout: simulation exceeded its time limit");
    $fatal(1, "[TB] aborted");
  end

  initial begin
    int w;
    rst      = 1'b0;
    in_valid = 1'b0;
    in_re    = '0;
    in_im    = '0;
    for (int k = 0; k < N_POINTS; k++) begin
      fft_out_re[k] = 16'h0A00 + 16'(k);
      fft_out_im[k] = 16'h0B00 + 16'(k);
    end
    repeat (3) @(posedge clk);

    // Reset values
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_fft_start", 32'(fft_start), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_timeout", 32'(timeout_err), 32'd0);
    check("rst_frame_count", 32'(frame_count), 32'd0);
    check("rst_out_index", 32'(out_index), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_out_re", 32'(out_re), 32'h0A00);
    check("rst_out_im", 32'(out_im), 32'h0B00);
    rst = 1'b1;

    // Frame 1: re = index, im = 0, launch timing and frame contents
    send_frame(0, 0);
    check("e0_fft_start", 32'(fft_start), 32'd0);
    check("e0_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    check("e1_fft_start", 32'(fft_start), 32'd1);
    check("e1_in_ready", 32'(in_ready), 32'd0);
    check("e1_busy", 32'(busy), 32'd1);
    for (int k = 0; k < N_POINTS; k++) begin
      check($sformatf("fft_in_re[%0d]", k), 32'(fft_in_re[k]), 32'(k));
    end
    check("fft_in_im[5]", 32'(fft_in_im[5]), 32'd0);
    @(posedge clk);
    check("e2_fft_start", 32'(fft_start), 32'd0);
    check("e2_in_ready", 32'(in_ready), 32'd1);
    check("run_busy", 32'(busy), 32'd1);
    wait_frames(1, 600);
    check("drain_len_full", 32'(last_drain_len), 32'd64);
    check("queue_empty_1", 32'(exp_q.size()), 32'd0);
    check("idle_busy_1", 32'(busy), 32'd0);

    // Frame 2: sink toggles ready every other cycle
    mode = 1;
    send_frame(200, 1);
    wait_frames(2, 1000);
    check("drain_len_toggle", 32'(last_drain_len), 32'd128);
    check("queue_empty_2", 32'(exp_q.size()), 32'd0);
    mode = 0;

    // Frames 3 and 4: second frame fills during RUN/DRAIN, back-to-back launch
    send_frame(300, 3);
    repeat (2) @(posedge clk);
    b2b_armed = 1'b1;
    send_frame(400, 5);
    check("overlap_in_ready", 32'(in_ready), 32'd0);
    check("overlap_busy", 32'(busy), 32'd1);
    wait_frames(4, 1500);
    check("b2b_observed", 32'(b2b_done), 32'd1);
    check("queue_empty_4", 32'(exp_q.size()), 32'd0);

    // Frame 5: core never answers, watchdog fires
    core_en    = 1'b0;
    valid_seen = 1'b0;
    send_frame(500, 1);
    w = 0;
    while (!timeout_err && w < 1300) begin
      @(posedge clk);
      w++;
    end
    check("timeout_err", 32'(timeout_err), 32'd1);
    check("timeout_cycles", 32'(($time - last_start_time) / PERIOD), 32'(TIMEOUT + 1));
    check("timeout_busy", 32'(busy), 32'd0);
    check("timeout_no_output", 32'(valid_seen), 32'd0);
    exp_q.delete();
    stray_req++;
    repeat (3) @(posedge clk);
    check("stray_done_valid", 32'(out_valid), 32'd0);
    check("stray_done_busy", 32'(busy), 32'd0);
    check("timeout_sticky", 32'(timeout_err), 32'd1);
    check("timeout_frames", 32'(frame_count), 32'd4);

    // Frame 6: reset asserted while the sink stalls at index 30
    core_en = 1'b1;
    mode    = 2;
    send_frame(600, 2);
    w = 0;
    while (!(out_valid && out_index == 6'd30) && w < 600) begin
      @(posedge clk);
      w++;
    end
    check("stall_at_30", 32'(out_index), 32'd30);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_timeout", 32'(timeout_err), 32'd0);
    check("arst_frame_count", 32'(frame_count), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd1);
    check("arst_out_index", 32'(out_index), 32'd0);
    check("arst_out_last", 32'(out_last), 32'd0);
    check("arst_out_re", 32'(out_re), 32'd1600);
    exp_q.delete();
    @(posedge clk);
    rst  = 1'b1;
    mode = 0;

    // Frame 7: normal operation after reset
    send_frame(700, 1);
    wait_frames(1, 600);
    check("drain_len_after_rst", 32'(last_drain_len), 32'd64);
    check("queue_empty_7", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/fft_frame_scheduler.md
# fft_frame_scheduler

Sequencing controller in front of the 64-point FFT core. It collects a frame of 64 complex samples from a streaming valid/ready source into a parallel buffer and launches the core with a one-cycle start pulse. After the core's done pulse, it drains the 64 results to a streaming valid/ready sink in index order. Collection of the next frame overlaps computation and draining of the current one, and a watchdog flags a core that never finishes.

## Interface
- N_POINTS, 64, samples per frame (power of two)
- LOG2_N, 6, index width
- DATA_W, 16, width of re/im words
- TIMEOUT_CYCLES, 1023, max RUN cycles before the watchdog fires
- clk  in  1  clock; all state updates on the falling edge, the same edge as the FFT core
- rst  in  1  reset, asynchronous, active-low
- in_valid / in_ready  in / out  1 / 1  input sample handshake
- in_re, in_im  in  DATA_W each  input sample, signed
- out_valid / out_ready  out / in  1 / 1  result handshake
- out_re, out_im  out  DATA_W each  result word
- out_index  out  LOG2_N  bin index of the current result
- out_last  out  1  high with index N_POINTS-1
- fft_start  out  1  one-cycle launch pulse to the core
- fft_in_re, fft_in_im  out  DATA_W x N_POINTS  parallel frame to the core
- fft_done  in  1  core completion pulse
- fft_out_re, fft_out_im  in  DATA_W x N_POINTS  core result arrays
- busy  out  1  FSM not in IDLE
- timeout_err  out  1  sticky watchdog flag; cleared only by rst
- frame_count  out  16  frames fully drained; wraps

## Operation
- Fill side: wr_ptr (LOG2_N bits) and buf_full.
  - in_ready = ~buf_full.
  - On each handshake, buf[wr_ptr] takes {in_re, in_im} and wr_ptr increments.
  - A handshake at wr_ptr = N_POINTS-1 wraps wr_ptr to 0 and sets buf_full.
- fft_in_re/fft_in_im are driven continuously from buf, which is stable while buf_full = 1.
- FSM states: IDLE, LAUNCH, RUN, DRAIN.
  - IDLE: buf_full -> LAUNCH.
  - LAUNCH: fft_start = 1. On this edge the core latches the buffer, buf_full clears, timer clears, and the FSM goes to RUN.
  - RUN: timer increments each edge.
    - fft_done = 1 -> DRAIN with rd_ptr = 0.
    - Timer reaching TIMEOUT_CYCLES with no done -> timeout_err = 1, go to IDLE. The frame is dropped and no output is produced.
  - DRAIN: out_valid = 1; out_re/out_im = fft_out_re/im[rd_ptr]; out_index = rd_ptr.
    - Each handshake increments rd_ptr.
    - A handshake at rd_ptr = N_POINTS-1 increments frame_count, then goes to LAUNCH if buf_full, else to IDLE.
- fft_done outside RUN is ignored.
- If fft_done and a timer expiry coincide, done wins and no error is raised.
- Output holds: core results stay valid until the next fft_start, so the core is never relaunched during DRAIN.
- Backpressure: out_valid stays high and the out_* signals stay stable while out_ready = 0. There is no limit on how long the sink may stall.
- Reset mid-operation: every state is cleared and partial or complete frames are discarded.
- Timer width is $clog2(TIMEOUT_CYCLES+1); the timer saturates and never wraps.

## Timing
- Reset values:
  - in_ready 1; out_valid 0; fft_start 0; busy 0; timeout_err 0; frame_count 0; out_index 0; out_last 0.
  - out_re/out_im follow fft_out_*[0].
- Launch latency: the last input handshake at edge E0 sets buf_full. The FSM enters LAUNCH at E0+1 (fft_start high), and the core latches the frame at E0+2.
- in_ready is low from E0 through E0+2 and returns high after E0+2.
- Drain: out_valid rises on the edge that samples fft_done high. At full throughput, one result transfers per cycle, so a drain takes 64 cycles.
- Back-to-back frames: if buf_full is already set at the final drain handshake, fft_start is asserted on the very next cycle.
- fft_start is registered, never combinational, and is exactly one cycle wide.

## Structure
- Package fft_ctrl_pkg: ctrl_state_t enum (IDLE, LAUNCH, RUN, DRAIN), plus the N_POINTS, LOG2_N and DATA_W constants.
- Sub-module fft_frame_buffer: the fill-side buffer with wr_ptr, buf_full, in_ready and a clear input driven from LAUNCH.
- The FSM, watchdog and drain mux live in the top module.

## Test plan
- Reset, then feed 64 samples with re = index, im = 0 and out_ready = 1 -> one fft_start pulse two edges after the 64th handshake; fft_in_re[k] = k.
- Model core returns done 200 cycles later with fft_out_re[k] = 1000+k -> out stream 1000..1063, out_last only on index 63, frame_count = 1.
- Sink toggles out_ready every other cycle -> no lost or duplicated words; out_re is held while stalled; drain takes 128 cycles.
- Source keeps sending during RUN/DRAIN -> second frame fills, in_ready drops at 64, fft_start fires the cycle after the first frame's last drain handshake.
- Model core never asserts done -> timeout_err = 1 after 1023 RUN cycles, FSM returns to IDLE, out_valid never rises, busy = 0.
- Assert rst low mid-DRAIN at index 30 -> all outputs return to reset values asynchronously; the next full frame processes normally.
